// File: rtl/cart_mapper_multi.sv
// Multi-context MSX-style cartridge bank mapper (KONAMI, KONAMI_SCC, ASCII8, ASCII16).
// Each cart context owns four bank registers and an SCC enable flag. Bank writes commit
// on the rising edge of the write strobe; address translation is purely combinational.
module cart_mapper_multi #(
    parameter int unsigned CARTS  = 2,
    parameter int unsigned BANK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] rom_size,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  din,
    input  logic        cpu_mreq,
    input  logic        cpu_wr,
    input  logic        cs,
    input  logic [1:0]  cart_num,
    input  logic [1:0]  mode,
    output logic [24:0] mem_addr,
    output logic        mem_unmaped,
    output logic        scc_sel,
    output logic        bank_wr
);

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned IDX_W  = (CARTS > 1) ? $clog2(CARTS) : 1;

    localparam logic [1:0] MODE_KONAMI     = 2'd0;
    localparam logic [1:0] MODE_KONAMI_SCC = 2'd1;
    localparam logic [1:0] MODE_ASCII8     = 2'd2;

    logic [BANK_W-1:0] bank_q [CARTS][4];
    logic [CARTS-1:0]  scc_en_q;
    // Set once the strobe has been observed low; a commit needs a fresh low-to-high edge.
    logic              armed_q;

    logic              strobe;
    logic              cart_ok;
    logic [IDX_W-1:0]  cart_idx;
    logic              wr_hit;
    logic [1:0]        wr_sel;
    logic [1:0]        page;
    logic [BANK_W-1:0] rd_bank;
    logic [BANK_W+12:0] addr_8k;
    logic [BANK_W+13:0] addr_16k;

    assign strobe   = cs & cpu_mreq & cpu_wr;
    assign cart_ok  = 32'(cart_num) < CARTS;
    // Out-of-range carts are clamped to context 0 for reads; they are flagged unmapped anyway.
    assign cart_idx = cart_ok ? IDX_W'(cart_num) : '0;
    assign page     = cpu_addr[14:13] ^ 2'b10;

    // Decode which bank register (if any) a CPU write targets in the current mode.
    always_comb begin
        wr_hit = 1'b0;
        wr_sel = 2'd0;
        case (mode)
            MODE_KONAMI: begin
                if (cpu_addr >= 16'h6000 && cpu_addr <= 16'hBFFF) begin
                    wr_hit = 1'b1;
                    wr_sel = page;
                end
            end
            MODE_KONAMI_SCC: begin
                // 5000h/7000h/9000h/B000h, each 2K wide
                if ((cpu_addr[15:14] == 2'b01 || cpu_addr[15:14] == 2'b10) &&
                    cpu_addr[12:11] == 2'b10) begin
                    wr_hit = 1'b1;
                    wr_sel = page;
                end
            end
            MODE_ASCII8: begin
                if (cpu_addr[15:13] == 3'b011) begin
                    wr_hit = 1'b1;
                    wr_sel = cpu_addr[12:11];
                end
            end
            default: begin
                // ASCII16: 6000h-67FFh and 7000h-77FFh only
                if (cpu_addr[15:13] == 3'b011 && !cpu_addr[11]) begin
                    wr_hit = 1'b1;
                    wr_sel = {1'b0, cpu_addr[12]};
                end
            end
        endcase
    end

    // Bank/SCC register file, strobe edge tracking and the registered bank_wr pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(CARTS); c++) begin
                for (int b = 0; b < 4; b++) begin
                    bank_q[c][b] <= BANK_W'(b);
                end
            end
            scc_en_q <= '0;
            armed_q  <= 1'b0;
            bank_wr  <= 1'b0;
        end else begin
            armed_q <= ~strobe;
            bank_wr <= 1'b0;
            if (strobe && armed_q && wr_hit && cart_ok) begin
                bank_q[cart_idx][wr_sel] <= BANK_W'(din);
                bank_wr                  <= 1'b1;
                if (mode == MODE_KONAMI_SCC && wr_sel == 2'd2) begin
                    scc_en_q[cart_idx] <= (din[5:0] == 6'h3F);
                end
            end
        end
    end

    // Translate the CPU address through the selected context's bank registers.
    always_comb begin
        rd_bank  = '0;
        addr_8k  = '0;
        addr_16k = '0;
        if (mode == 2'd3) begin
            rd_bank  = bank_q[cart_idx][cpu_addr[15] ? 2'd1 : 2'd0];
            addr_16k = {rd_bank, cpu_addr[13:0]};
            mem_addr = ADDR_W'(addr_16k);
        end else begin
            // KONAMI hardwires page 0 to bank 0
            rd_bank  = (mode == MODE_KONAMI && page == 2'd0) ? '0 : bank_q[cart_idx][page];
            addr_8k  = {rd_bank, cpu_addr[12:0]};
            mem_addr = ADDR_W'(addr_8k);
        end
    end

    // SCC register window decode and unmapped-access detection.
    always_comb begin
        scc_sel     = cs && mode == MODE_KONAMI_SCC && cart_ok && scc_en_q[cart_idx] &&
                      cpu_addr[15:11] == 5'b10011;
        mem_unmaped = cs && !scc_sel &&
                      (cpu_addr < 16'h4000 || cpu_addr >= 16'hC000 ||
                       mem_addr > rom_size || !cart_ok);
    end

endmodule

// File: tb/tb_cart_mapper_multi.sv
// Randomized self-checking bench for cart_mapper_multi against a behavioural model.
module tb_cart_mapper_multi;

    localparam int unsigned CARTS  = 2;
    localparam int unsigned BANK_W = 8;

    logic        clk;
    logic        reset;
    logic [24:0] rom_size;
    logic [15:0] cpu_addr;
    logic [7:0]  din;
    logic        cpu_mreq;
    logic        cpu_wr;
    logic        cs;
    logic [1:0]  cart_num;
    logic [1:0]  mode;
    logic [24:0] mem_addr;
    logic        mem_unmaped;
    logic        scc_sel;
    logic        bank_wr;

    cart_mapper_multi #(.CARTS(CARTS), .BANK_W(BANK_W)) dut (
        .clk(clk), .reset(reset), .rom_size(rom_size), .cpu_addr(cpu_addr),
        .din(din), .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr), .cs(cs),
        .cart_num(cart_num), .mode(mode), .mem_addr(mem_addr),
        .mem_unmaped(mem_unmaped), .scc_sel(scc_sel), .bank_wr(bank_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_bank [4][4];
    bit m_scc  [4];
    bit m_prev;      // strobe level seen at last edge (1 after reset: needs a low first)
    bit exp_bw;
    int pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) m_bank[c][b] = b;
            m_scc[c] = 0;
        end
        m_prev = 1;
        exp_bw = 0;
    endtask

    function automatic int m_target(int md, int a);
        case (md)
            0: begin
                if (a >= 'h6000 && a <= 'h7FFF) return 1;
                if (a >= 'h8000 && a <= 'h9FFF) return 2;
                if (a >= 'hA000 && a <= 'hBFFF) return 3;
            end
            1: begin
                if (a >= 'h5000 && a <= 'h57FF) return 0;
                if (a >= 'h7000 && a <= 'h77FF) return 1;
                if (a >= 'h9000 && a <= 'h97FF) return 2;
                if (a >= 'hB000 && a <= 'hB7FF) return 3;
            end
            2: begin
                if (a >= 'h6000 && a <= 'h67FF) return 0;
                if (a >= 'h6800 && a <= 'h6FFF) return 1;
                if (a >= 'h7000 && a <= 'h77FF) return 2;
                if (a >= 'h7800 && a <= 'h7FFF) return 3;
            end
            default: begin
                if (a >= 'h6000 && a <= 'h67FF) return 0;
                if (a >= 'h7000 && a <= 'h77FF) return 1;
            end
        endcase
        return -1;
    endfunction

    // Expected translated address for an access inside 4000h-BFFFh of a valid cart.
    function automatic int m_addr(int md, int c, int a);
        int bank;
        int pg;
        if (md == 3) begin
            bank = (a >= 'h8000) ? m_bank[c][1] : m_bank[c][0];
            return bank * 16384 + (a % 16384);
        end
        pg   = (a - 'h4000) / 8192;
        bank = (md == 0 && pg == 0) ? 0 : m_bank[c][pg];
        return bank * 8192 + (a % 8192);
    endfunction

    // Model update on a rising clock edge, using the inputs held across that edge.
    task automatic model_edge();
        bit s;
        int t;
        s = cs && cpu_mreq && cpu_wr;
        if (reset) begin
            model_reset();
            return;
        end
        exp_bw = 0;
        if (s && !m_prev && cart_num < CARTS) begin
            t = m_target(int'(mode), int'(cpu_addr));
            if (t >= 0) begin
                m_bank[cart_num][t] = int'(din) % (1 << BANK_W);
                exp_bw = 1;
                if (mode == 2'd1 && t == 2) m_scc[cart_num] = (din % 64 == 63);
            end
        end
        m_prev = s;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (bank_wr) pulses++;
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic check_all(input string tag);
        int a;
        int e_addr;
        bit valid;
        bit e_scc;
        bit e_unm;
        #1;
        a      = int'(cpu_addr);
        valid  = cart_num < CARTS;
        e_addr = valid ? m_addr(int'(mode), int'(cart_num), a) : 0;
        e_scc  = cs && mode == 2'd1 && valid && m_scc[cart_num] && a >= 'h9800 && a <= 'h9FFF;
        e_unm  = cs && !e_scc && (a < 'h4000 || a >= 'hC000 || !valid || e_addr > int'(rom_size));
        if (valid && a >= 'h4000 && a < 'hC000) chk({tag, ".addr"}, 32'(mem_addr), 32'(e_addr));
        chk({tag, ".scc"}, 32'(scc_sel), 32'(e_scc));
        chk({tag, ".unm"}, 32'(mem_unmaped), 32'(e_unm));
        chk({tag, ".bw"}, 32'(bank_wr), 32'(exp_bw));
    endtask

    task automatic set_rd(input logic [1:0] md, input logic [1:0] c, input logic [15:0] a);
        cs = 1; cpu_mreq = 1; cpu_wr = 0; mode = md; cart_num = c; cpu_addr = a;
    endtask

    // Hold a write strobe for n cycles, then drop it for one cycle.
    task automatic do_wr(input logic [1:0] md, input logic [1:0] c, input logic [15:0] a,
                         input logic [7:0] d, input int n);
        cs = 1; cpu_mreq = 1; cpu_wr = 1; mode = md; cart_num = c; cpu_addr = a; din = d;
        for (int i = 0; i < n; i++) begin
            tick();
            check_all("wr");
        end
        cpu_wr = 0;
        tick();
        check_all("wr_end");
    endtask

    localparam int NWIN = 10;
    logic [15:0] win [NWIN] = '{16'h5000, 16'h6000, 16'h6800, 16'h7000, 16'h7800,
                                16'h8000, 16'h9000, 16'h9800, 16'hA000, 16'hB000};

    initial begin
        reset = 1; cs = 0; cpu_mreq = 0; cpu_wr = 0; cpu_addr = 0; din = 0;
        cart_num = 0; mode = 0; rom_size = 25'h1FFFFFF; pulses = 0;
        model_reset();
        #12 reset = 0;
        tick();

        // Reset state
        set_rd(2'd0, 2'd0, 16'h8123);
        check_all("rst");
        chk("rst_map", 32'(mem_addr), 32'h4123);
        chk("rst_bw", 32'(bank_wr), 32'h0);

        // KONAMI write b2 on cart 0
        pulses = 0;
        do_wr(2'd0, 2'd0, 16'h8000, 8'h05, 1);
        chk("konami_pulses", 32'(pulses), 32'd1);
        set_rd(2'd0, 2'd0, 16'h8123); check_all("k0");
        chk("konami_c0", 32'(mem_addr), 32'h00A123);
        set_rd(2'd0, 2'd1, 16'h8123); check_all("k1");
        chk("konami_c1", 32'(mem_addr), 32'h004123);

        // ASCII8 strobe held 4 cycles
        pulses = 0;
        do_wr(2'd2, 2'd0, 16'h6000, 8'h07, 4);
        chk("ascii8_pulses", 32'(pulses), 32'd1);
        set_rd(2'd2, 2'd0, 16'h4010); check_all("a8");
        chk("ascii8_map", 32'(mem_addr), 32'h00E010);

        // KONAMI_SCC enable / disable
        do_wr(2'd1, 2'd0, 16'h9000, 8'h3F, 1);
        set_rd(2'd1, 2'd0, 16'h9800); check_all("scc_on");
        chk("scc_on", 32'(scc_sel), 32'h1);
        chk("scc_on_unm", 32'(mem_unmaped), 32'h0);
        do_wr(2'd1, 2'd0, 16'h9000, 8'h3E, 1);
        set_rd(2'd1, 2'd0, 16'h9800); check_all("scc_off");
        chk("scc_off", 32'(scc_sel), 32'h0);

        // ASCII16 with small ROM
        do_wr(2'd3, 2'd0, 16'h7000, 8'h03, 1);
        set_rd(2'd3, 2'd0, 16'h8001); check_all("a16");
        chk("ascii16_map", 32'(mem_addr), 32'h00C001);
        rom_size = 25'h007FFF;
        check_all("a16_small");
        chk("ascii16_unm", 32'(mem_unmaped), 32'h1);
        rom_size = 25'h1FFFFFF;

        // Outside the cartridge window
        set_rd(2'd0, 2'd0, 16'h2000); check_all("lo");
        chk("unm_2000", 32'(mem_unmaped), 32'h1);
        set_rd(2'd0, 2'd0, 16'hC000); check_all("hi");
        chk("unm_c000", 32'(mem_unmaped), 32'h1);
        pulses = 0;
        do_wr(2'd0, 2'd0, 16'hC000, 8'h11, 1);
        chk("wr_c000_pulses", 32'(pulses), 32'd0);

        // Out-of-range cart: write ignored, access unmapped
        pulses = 0;
        do_wr(2'd0, 2'd3, 16'h8000, 8'h22, 1);
        chk("badcart_pulses", 32'(pulses), 32'd0);
        set_rd(2'd0, 2'd2, 16'h8000); check_all("badcart");
        chk("badcart_unm", 32'(mem_unmaped), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1)) cpu_wr = 1'($urandom_range(0, 1));
            cpu_mreq = ($urandom_range(0, 7) != 0);
            cs       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            cart_num = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1)) cpu_addr = win[$urandom_range(0, NWIN - 1)] + 16'($urandom_range(0, 'h7FF));
            else cpu_addr = 16'($urandom_range(0, 'hFFFF));
            din = ($urandom_range(0, 3) == 0) ? 8'h3F : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: rom_size = 25'h1FFFFFF;
                1: rom_size = 25'h007FFF;
                default: rom_size = 25'($urandom_range(0, 'h3FFFFF));
            endcase
            check_all("rnd");
            tick();
        end

        // Async reset mid-strobe after writes; banks return without a clock edge
        do_wr(2'd0, 2'd0, 16'hA000, 8'h44, 1);
        rom_size = 25'h1FFFFFF;
        cs = 1; cpu_mreq = 1; cpu_wr = 1; mode = 0; cart_num = 0; cpu_addr = 16'hA000; din = 8'h55;
        @(posedge clk);
        model_edge();
        #2 reset = 1;
        #1 model_reset();
        check_all("arst");
        chk("arst_map", 32'(mem_addr), 32'h006000);
        chk("arst_bw", 32'(bank_wr), 32'h0);
        tick();
        #2 reset = 0;
        pulses = 0;
        tick(); check_all("post_rst");
        tick(); check_all("post_rst2");
        chk("rst_strobe_pulses", 32'(pulses), 32'd0);
        chk("rst_strobe_map", 32'(mem_addr), 32'h006000);
        cpu_wr = 0; tick(); check_all("rearm");
        cpu_wr = 1; tick(); check_all("rearm_wr");
        chk("rearm_bw", 32'(bank_wr), 32'h1);
        cpu_wr = 0; tick(); check_all("rearm_end");
        chk("rearm_map", 32'(mem_addr), 32'h00A000 + 32'h02000 * 32'h50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
